// File: rtl/mc_defs.sv
`default_nettype none
// ============================================================================
// Module      : mc_defs (package)
// Description : Shared constants for the multi-cycle MIPS control unit:
//               opcodes, functs, ALU operation codes, FSM state encodings,
//               ALU decode classes and datapath mux select codes.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_defs;

   localparam int c_state_w = 4;

   // Controller states; any other encoding is recovered through FETCH
   typedef enum logic [c_state_w-1:0] {
      ST_INIT      = 4'd0,
      ST_FETCH     = 4'd1,
      ST_DECODE    = 4'd2,
      ST_MEM_ADDR  = 4'd3,
      ST_MEM_READ  = 4'd4,
      ST_MEM_WB    = 4'd5,
      ST_MEM_WRITE = 4'd6,
      ST_R_EXEC    = 4'd7,
      ST_I_EXEC    = 4'd8,
      ST_ALU_WB    = 4'd9,
      ST_BRANCH    = 4'd10,
      ST_JUMP      = 4'd11,
      ST_JR        = 4'd12,
      ST_JAL       = 4'd13
   } state_t;

   // What the ALU is being used for in the current state
   typedef enum logic [2:0] {
      CLS_NONE     = 3'd0,
      CLS_PC_INC   = 3'd1,
      CLS_BR_TGT   = 3'd2,
      CLS_MEM_ADDR = 3'd3,
      CLS_R_EXEC   = 3'd4,
      CLS_I_EXEC   = 3'd5,
      CLS_BR_CMP   = 3'd6
   } alu_cls_t;

   // Opcodes (IR[31:26])
   localparam logic [5:0] c_op_rtype = 6'h00;
   localparam logic [5:0] c_op_j     = 6'h02;
   localparam logic [5:0] c_op_jal   = 6'h03;
   localparam logic [5:0] c_op_beq   = 6'h04;
   localparam logic [5:0] c_op_ori   = 6'h0D;
   localparam logic [5:0] c_op_lui   = 6'h0F;
   localparam logic [5:0] c_op_lw    = 6'h23;
   localparam logic [5:0] c_op_sw    = 6'h2B;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] c_fn_sll  = 6'h00;
   localparam logic [5:0] c_fn_jr   = 6'h08;
   localparam logic [5:0] c_fn_addu = 6'h21;
   localparam logic [5:0] c_fn_subu = 6'h23;
   localparam logic [5:0] c_fn_and  = 6'h24;
   localparam logic [5:0] c_fn_or   = 6'h25;

   // ALU operation codes
   localparam logic [2:0] c_alu_and = 3'd0;
   localparam logic [2:0] c_alu_or  = 3'd1;
   localparam logic [2:0] c_alu_add = 3'd2;
   localparam logic [2:0] c_alu_sub = 3'd3;
   localparam logic [2:0] c_alu_sll = 3'd4;

   // Register file destination select
   localparam logic [1:0] c_rd_rt = 2'd0;
   localparam logic [1:0] c_rd_rd = 2'd1;
   localparam logic [1:0] c_rd_ra = 2'd2;

   // Write-back data select
   localparam logic [1:0] c_m2r_alu = 2'd0;
   localparam logic [1:0] c_m2r_mdr = 2'd1;
   localparam logic [1:0] c_m2r_pc  = 2'd2;

   // ALU operand A select
   localparam logic [1:0] c_sa_pc  = 2'd0;
   localparam logic [1:0] c_sa_rs  = 2'd1;
   localparam logic [1:0] c_sa_rt  = 2'd2;
   localparam logic [1:0] c_sa_imm = 2'd3;

   // ALU operand B select
   localparam logic [2:0] c_sb_rt      = 3'd0;
   localparam logic [2:0] c_sb_four    = 3'd1;
   localparam logic [2:0] c_sb_sext    = 3'd2;
   localparam logic [2:0] c_sb_zext    = 3'd3;
   localparam logic [2:0] c_sb_sext_s2 = 3'd4;
   localparam logic [2:0] c_sb_shamt   = 3'd5;
   localparam logic [2:0] c_sb_sixteen = 3'd6;

   // PC source select
   localparam logic [1:0] c_pc_alu    = 2'd0;
   localparam logic [1:0] c_pc_aluout = 2'd1;
   localparam logic [1:0] c_pc_jump   = 2'd2;
   localparam logic [1:0] c_pc_rs     = 2'd3;

   // R-type functs that go through the ALU execute/write-back path
   function automatic logic is_alu_funct(input logic [5:0] f);
      return (f == c_fn_addu) || (f == c_fn_subu) || (f == c_fn_and) ||
             (f == c_fn_or)   || (f == c_fn_sll);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mc_control_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_fsm_if
// Description : Control-unit <-> datapath signal bundle. The master side is
//               the control FSM, the slave side is the datapath/memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_control_fsm_if #(
   parameter int STATE_W = 4
);
   logic [5:0]         op;
   logic [5:0]         funct;
   logic               zero;
   logic               mem_ready;
   logic               pc_write;
   logic               pc_write_cond;
   logic               i_or_d;
   logic               mem_read;
   logic               mem_write;
   logic               ir_write;
   logic               reg_write;
   logic [1:0]         reg_dst;
   logic [1:0]         mem_to_reg;
   logic [1:0]         alu_src_a;
   logic [2:0]         alu_src_b;
   logic [2:0]         alu_op;
   logic [1:0]         pc_src;
   logic [STATE_W-1:0] state;
   logic               retire;
   logic               illegal;

   modport master (
      input  op, funct, zero, mem_ready,
      output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
             pc_src, state, retire, illegal
   );

   modport slave (
      output op, funct, zero, mem_ready,
      input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
             pc_src, state, retire, illegal
   );
endinterface
`default_nettype wire

// File: rtl/mc_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mc_alu_decoder
// Description : Maps the ALU usage class of the current state plus the
//               instruction op/funct to ALU operation and operand selects.
//               Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_alu_decoder
   import mc_defs::*;
(
   input  alu_cls_t   i_cls,
   input  logic [5:0] i_op,
   input  logic [5:0] i_funct,
   output logic [2:0] o_alu_op,
   output logic [1:0] o_alu_src_a,
   output logic [2:0] o_alu_src_b
);

   // Operand/operation selection; everything idles at zero outside ALU states
   always_comb begin
      o_alu_op    = 3'd0;
      o_alu_src_a = 2'd0;
      o_alu_src_b = 3'd0;
      case (i_cls)
         CLS_PC_INC: begin
            o_alu_src_a = c_sa_pc;
            o_alu_src_b = c_sb_four;
            o_alu_op    = c_alu_add;
         end
         CLS_BR_TGT: begin
            o_alu_src_a = c_sa_pc;
            o_alu_src_b = c_sb_sext_s2;
            o_alu_op    = c_alu_add;
         end
         CLS_MEM_ADDR: begin
            o_alu_src_a = c_sa_rs;
            o_alu_src_b = c_sb_sext;
            o_alu_op    = c_alu_add;
         end
         CLS_R_EXEC: begin
            o_alu_src_a = c_sa_rs;
            o_alu_src_b = c_sb_rt;
            o_alu_op    = c_alu_add;
            case (i_funct)
               c_fn_subu: o_alu_op = c_alu_sub;
               c_fn_and:  o_alu_op = c_alu_and;
               c_fn_or:   o_alu_op = c_alu_or;
               c_fn_sll: begin
                  // shift the rt operand by the shamt field
                  o_alu_src_a = c_sa_rt;
                  o_alu_src_b = c_sb_shamt;
                  o_alu_op    = c_alu_sll;
               end
               default: ;
            endcase
         end
         CLS_I_EXEC: begin
            if (i_op == c_op_lui) begin
               // lui is imm16 << 16 through the shifter
               o_alu_src_a = c_sa_imm;
               o_alu_src_b = c_sb_sixteen;
               o_alu_op    = c_alu_sll;
            end else begin
               o_alu_src_a = c_sa_rs;
               o_alu_src_b = c_sb_zext;
               o_alu_op    = c_alu_or;
            end
         end
         CLS_BR_CMP: begin
            o_alu_src_a = c_sa_rs;
            o_alu_src_b = c_sb_rt;
            o_alu_op    = c_alu_sub;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_fsm
// Description : Multi-cycle MIPS control unit. Moore FSM sequencing
//               fetch/decode/execute/memory/write-back and driving the ALU
//               controls, operand muxes and datapath write enables.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_control_fsm
   import mc_defs::*;
#(
   parameter int STATE_W = 4
)(
   input  logic              clk,
   input  logic              reset_n,
   mc_control_fsm_if.master  bus
);

   state_t     r_state;
   state_t     w_next;
   alu_cls_t   w_cls;
   logic       w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_read, w_mem_write;
   logic       w_ir_write, w_reg_write, w_retire, w_illegal;
   logic [1:0] w_reg_dst, w_mem_to_reg, w_pc_src, w_alu_src_a;
   logic [2:0] w_alu_src_b, w_alu_op;
   logic       w_unused_zero;

   // The zero flag only qualifies pc_write_cond inside the datapath
   assign w_unused_zero = bus.zero;

   // State register, cleared to INIT immediately on reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_INIT;
      else          r_state <= w_next;
   end

   // Next-state and per-state control outputs
   always_comb begin
      w_next          = ST_FETCH;
      w_cls           = CLS_NONE;
      w_pc_write      = 1'b0;
      w_pc_write_cond = 1'b0;
      w_i_or_d        = 1'b0;
      w_mem_read      = 1'b0;
      w_mem_write     = 1'b0;
      w_ir_write      = 1'b0;
      w_reg_write     = 1'b0;
      w_retire        = 1'b0;
      w_illegal       = 1'b0;
      w_reg_dst       = c_rd_rt;
      w_mem_to_reg    = c_m2r_alu;
      w_pc_src        = c_pc_alu;
      case (r_state)
         ST_INIT: w_next = ST_FETCH;
         ST_FETCH: begin
            w_cls      = CLS_PC_INC;
            w_mem_read = 1'b1;
            w_ir_write = bus.mem_ready;
            w_pc_write = bus.mem_ready;
            w_next     = bus.mem_ready ? ST_DECODE : ST_FETCH;
         end
         ST_DECODE: begin
            w_cls = CLS_BR_TGT;
            if (bus.op == c_op_rtype) begin
               if (bus.funct == c_fn_jr)          w_next = ST_JR;
               else if (is_alu_funct(bus.funct))  w_next = ST_R_EXEC;
               else begin
                  w_illegal = 1'b1;
                  w_retire  = 1'b1;
               end
            end else begin
               case (bus.op)
                  c_op_lw, c_op_sw:   w_next = ST_MEM_ADDR;
                  c_op_ori, c_op_lui: w_next = ST_I_EXEC;
                  c_op_beq:           w_next = ST_BRANCH;
                  c_op_j:             w_next = ST_JUMP;
                  c_op_jal:           w_next = ST_JAL;
                  default: begin
                     w_illegal = 1'b1;
                     w_retire  = 1'b1;
                  end
               endcase
            end
         end
         ST_MEM_ADDR: begin
            w_cls  = CLS_MEM_ADDR;
            w_next = (bus.op == c_op_lw) ? ST_MEM_READ : ST_MEM_WRITE;
         end
         ST_MEM_READ: begin
            w_i_or_d   = 1'b1;
            w_mem_read = 1'b1;
            w_next     = bus.mem_ready ? ST_MEM_WB : ST_MEM_READ;
         end
         ST_MEM_WB: begin
            w_reg_dst    = c_rd_rt;
            w_mem_to_reg = c_m2r_mdr;
            w_reg_write  = 1'b1;
            w_retire     = 1'b1;
         end
         ST_MEM_WRITE: begin
            w_i_or_d    = 1'b1;
            w_mem_write = 1'b1;
            w_retire    = bus.mem_ready;
            w_next      = bus.mem_ready ? ST_FETCH : ST_MEM_WRITE;
         end
         ST_R_EXEC: begin
            w_cls  = CLS_R_EXEC;
            w_next = ST_ALU_WB;
         end
         ST_I_EXEC: begin
            w_cls  = CLS_I_EXEC;
            w_next = ST_ALU_WB;
         end
         ST_ALU_WB: begin
            w_reg_dst    = (bus.op == c_op_rtype) ? c_rd_rd : c_rd_rt;
            w_mem_to_reg = c_m2r_alu;
            w_reg_write  = 1'b1;
            w_retire     = 1'b1;
         end
         ST_BRANCH: begin
            w_cls           = CLS_BR_CMP;
            w_pc_src        = c_pc_aluout;
            w_pc_write_cond = 1'b1;
            w_retire        = 1'b1;
         end
         ST_JUMP: begin
            w_pc_src   = c_pc_jump;
            w_pc_write = 1'b1;
            w_retire   = 1'b1;
         end
         ST_JR: begin
            w_pc_src   = c_pc_rs;
            w_pc_write = 1'b1;
            w_retire   = 1'b1;
         end
         ST_JAL: begin
            w_reg_dst    = c_rd_ra;
            w_mem_to_reg = c_m2r_pc;
            w_reg_write  = 1'b1;
            w_pc_src     = c_pc_jump;
            w_pc_write   = 1'b1;
            w_retire     = 1'b1;
         end
         default: w_next = ST_FETCH;
      endcase
   end

   mc_alu_decoder u_alu_dec (
      .i_cls       (w_cls),
      .i_op        (bus.op),
      .i_funct     (bus.funct),
      .o_alu_op    (w_alu_op),
      .o_alu_src_a (w_alu_src_a),
      .o_alu_src_b (w_alu_src_b)
   );

   assign bus.pc_write      = w_pc_write;
   assign bus.pc_write_cond = w_pc_write_cond;
   assign bus.i_or_d        = w_i_or_d;
   assign bus.mem_read      = w_mem_read;
   assign bus.mem_write     = w_mem_write;
   assign bus.ir_write      = w_ir_write;
   assign bus.reg_write     = w_reg_write;
   assign bus.reg_dst       = w_reg_dst;
   assign bus.mem_to_reg    = w_mem_to_reg;
   assign bus.alu_src_a     = w_alu_src_a;
   assign bus.alu_src_b     = w_alu_src_b;
   assign bus.alu_op        = w_alu_op;
   assign bus.pc_src        = w_pc_src;
   assign bus.state         = STATE_W'(r_state);
   assign bus.retire        = w_retire;
   assign bus.illegal       = w_illegal;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_control_fsm
// Description : Self-checking bench for the multi-cycle control unit. Each
//               instruction is expanded into the cycle list the instruction
//               set description implies, and every cycle is compared.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control_fsm;
   import mc_defs::*;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic [1:0] alu_src_a;
      logic [2:0] alu_src_b;
      logic [2:0] alu_op;
      logic [1:0] pc_src;
      logic [3:0] state;
      logic       retire;
      logic       illegal;
   } ctl_t;

   typedef struct {
      logic [5:0] op;
      logic [5:0] funct;
      int         cycles;
      int         idx;
      logic [2:0] alu_op;
      logic [1:0] src_a;
      logic [2:0] src_b;
   } vec_t;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;
   ctl_t steps[$];
   bit   waits[$];
   ctl_t act_log[64];

   mc_control_fsm_if #(.STATE_W(4)) bus ();

   mc_control_fsm #(.STATE_W(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ctl_t sample();
      ctl_t a;
      a.pc_write      = bus.pc_write;
      a.pc_write_cond = bus.pc_write_cond;
      a.i_or_d        = bus.i_or_d;
      a.mem_read      = bus.mem_read;
      a.mem_write     = bus.mem_write;
      a.ir_write      = bus.ir_write;
      a.reg_write     = bus.reg_write;
      a.reg_dst       = bus.reg_dst;
      a.mem_to_reg    = bus.mem_to_reg;
      a.alu_src_a     = bus.alu_src_a;
      a.alu_src_b     = bus.alu_src_b;
      a.alu_op        = bus.alu_op;
      a.pc_src        = bus.pc_src;
      a.state         = bus.state;
      a.retire        = bus.retire;
      a.illegal       = bus.illegal;
      return a;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, want, $time);
      end
   endtask

   function automatic ctl_t at(input state_t st);
      ctl_t e = '0;
      e.state = st;
      return e;
   endfunction

   // Expand one instruction into its per-cycle expected controls
   task automatic build(input logic [5:0] op, input logic [5:0] fn);
      ctl_t e;
      string kind;
      steps.delete();
      waits.delete();
      e = at(ST_FETCH);
      e.mem_read = 1; e.alu_src_b = 3'd1; e.alu_op = 3'd2;
      e.pc_write = 1; e.ir_write = 1;
      steps.push_back(e); waits.push_back(1);
      if (op == 6'h00) begin
         case (fn)
            6'h21: kind = "addu";
            6'h23: kind = "subu";
            6'h24: kind = "and";
            6'h25: kind = "or";
            6'h00: kind = "sll";
            6'h08: kind = "jr";
            default: kind = "bad";
         endcase
      end else begin
         case (op)
            6'h23: kind = "lw";
            6'h2B: kind = "sw";
            6'h0D: kind = "ori";
            6'h0F: kind = "lui";
            6'h04: kind = "beq";
            6'h02: kind = "j";
            6'h03: kind = "jal";
            default: kind = "bad";
         endcase
      end
      e = at(ST_DECODE);
      e.alu_src_b = 3'd4; e.alu_op = 3'd2;
      if (kind == "bad") begin
         e.illegal = 1; e.retire = 1;
         steps.push_back(e); waits.push_back(0);
         return;
      end
      steps.push_back(e); waits.push_back(0);
      if (kind == "lw" || kind == "sw") begin
         e = at(ST_MEM_ADDR); e.alu_src_a = 2'd1; e.alu_src_b = 3'd2; e.alu_op = 3'd2;
         steps.push_back(e); waits.push_back(0);
         if (kind == "lw") begin
            e = at(ST_MEM_READ); e.i_or_d = 1; e.mem_read = 1;
            steps.push_back(e); waits.push_back(1);
            e = at(ST_MEM_WB); e.mem_to_reg = 2'd1; e.reg_write = 1; e.retire = 1;
            steps.push_back(e); waits.push_back(0);
         end else begin
            e = at(ST_MEM_WRITE); e.i_or_d = 1; e.mem_write = 1; e.retire = 1;
            steps.push_back(e); waits.push_back(1);
         end
      end else if (kind == "beq") begin
         e = at(ST_BRANCH); e.alu_src_a = 2'd1; e.alu_op = 3'd3;
         e.pc_src = 2'd1; e.pc_write_cond = 1; e.retire = 1;
         steps.push_back(e); waits.push_back(0);
      end else if (kind == "j" || kind == "jr" || kind == "jal") begin
         e = at(kind == "j" ? ST_JUMP : kind == "jr" ? ST_JR : ST_JAL);
         e.pc_write = 1; e.retire = 1;
         e.pc_src = (kind == "jr") ? 2'd3 : 2'd2;
         if (kind == "jal") begin
            e.reg_dst = 2'd2; e.mem_to_reg = 2'd2; e.reg_write = 1;
         end
         steps.push_back(e); waits.push_back(0);
      end else begin
         e = at((op == 6'h00) ? ST_R_EXEC : ST_I_EXEC);
         e.alu_src_a = 2'd1;
         case (kind)
            "addu": e.alu_op = 3'd2;
            "subu": e.alu_op = 3'd3;
            "and":  e.alu_op = 3'd0;
            "or":   e.alu_op = 3'd1;
            "sll":  begin e.alu_src_a = 2'd2; e.alu_src_b = 3'd5; e.alu_op = 3'd4; end
            "ori":  begin e.alu_src_b = 3'd3; e.alu_op = 3'd1; end
            default: begin e.alu_src_a = 2'd3; e.alu_src_b = 3'd6; e.alu_op = 3'd4; end
         endcase
         steps.push_back(e); waits.push_back(0);
         e = at(ST_ALU_WB); e.reg_write = 1; e.retire = 1;
         e.reg_dst = (op == 6'h00) ? 2'd1 : 2'd0;
         steps.push_back(e); waits.push_back(0);
      end
   endtask

   // rmode: 0 ready always, 1 random ready, 2 ready low for the first two
   // cycles of every post-fetch memory wait. zmode: 0/1 fixed zero, 2 random.
   // abort_idx: assert reset in that step after its outputs were checked.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int rmode,
                            input int zmode, input int abort_idx, output int ncyc);
      int   idx = 0;
      int   wcnt = 0;
      logic rdy;
      ctl_t e;
      ctl_t a;
      ncyc = 0;
      build(op, fn);
      while (idx < steps.size()) begin
         @(posedge clk); #1;
         bus.op    = op;
         bus.funct = fn;
         if (rmode == 1)      rdy = (wcnt >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
         else if (rmode == 2) rdy = !(waits[idx] && idx > 0 && wcnt < 2);
         else                 rdy = 1'b1;
         bus.mem_ready = rdy;
         bus.zero      = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
         @(negedge clk);
         e = steps[idx];
         if (waits[idx] && !rdy) begin
            e.pc_write = 0; e.ir_write = 0; e.retire = 0;
         end
         a = sample();
         if (ncyc < 64) act_log[ncyc] = a;
         ncyc++;
         chk($sformatf("op%h/fn%h step%0d ctl", op, fn, idx), 32'(a), 32'(e));
         if (idx == abort_idx) begin
            reset_n = 1'b0;
            #1;
            chk("reset_mid_instr ctl", 32'(sample()), 32'(at(ST_INIT)));
            return;
         end
         if (waits[idx] && !rdy) begin
            wcnt++;
            if (ncyc > 60) begin
               errors++;
               $display("FAIL timeout: got %0d cycles expected <= 60", ncyc);
               return;
            end
         end else begin
            idx++;
            wcnt = 0;
         end
      end
   endtask

   function automatic int first_retire(input int n);
      for (int i = 0; i < n && i < 64; i++)
         if (act_log[i].retire) return i + 1;
      return 0;
   endfunction

   initial begin
      vec_t vecs[15];
      int   n;
      int   cnt_w;
      int   cnt_r;
      logic [5:0] rop, rfn;
      logic [5:0] legal_ops[13];
      logic [5:0] legal_fns[13];

      checks = 0;
      errors = 0;
      vecs[0]  = '{6'h23, 6'h00, 5, 2, 3'd2, 2'd1, 3'd2};
      vecs[1]  = '{6'h2B, 6'h11, 4, 2, 3'd2, 2'd1, 3'd2};
      vecs[2]  = '{6'h00, 6'h21, 4, 2, 3'd2, 2'd1, 3'd0};
      vecs[3]  = '{6'h00, 6'h23, 4, 2, 3'd3, 2'd1, 3'd0};
      vecs[4]  = '{6'h00, 6'h24, 4, 2, 3'd0, 2'd1, 3'd0};
      vecs[5]  = '{6'h00, 6'h25, 4, 2, 3'd1, 2'd1, 3'd0};
      vecs[6]  = '{6'h00, 6'h00, 4, 2, 3'd4, 2'd2, 3'd5};
      vecs[7]  = '{6'h0D, 6'h3A, 4, 2, 3'd1, 2'd1, 3'd3};
      vecs[8]  = '{6'h0F, 6'h00, 4, 2, 3'd4, 2'd3, 3'd6};
      vecs[9]  = '{6'h04, 6'h05, 3, 2, 3'd3, 2'd1, 3'd0};
      vecs[10] = '{6'h02, 6'h00, 3, 1, 3'd2, 2'd0, 3'd4};
      vecs[11] = '{6'h00, 6'h08, 3, 1, 3'd2, 2'd0, 3'd4};
      vecs[12] = '{6'h03, 6'h00, 3, 0, 3'd2, 2'd0, 3'd1};
      vecs[13] = '{6'h3F, 6'h00, 2, 1, 3'd2, 2'd0, 3'd4};
      vecs[14] = '{6'h00, 6'h3F, 2, 1, 3'd2, 2'd0, 3'd4};
      legal_ops = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                    6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};
      legal_fns = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h00, 6'h08,
                    6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

      // Reset held three cycles, then released
      reset_n       = 1'b0;
      bus.op        = 6'h00;
      bus.funct     = 6'h00;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("reset_hold ctl", 32'(sample()), 32'(at(ST_INIT)));
      end
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);
      chk("reset_release ctl", 32'(sample()), 32'(at(ST_INIT)));

      // Table: every instruction with memory always ready
      foreach (vecs[i]) begin
         run_instr(vecs[i].op, vecs[i].funct, 0, 2, -1, n);
         chk($sformatf("vec%0d cycles", i), 32'(first_retire(n)), 32'(vecs[i].cycles));
         chk($sformatf("vec%0d alu", i),
             32'({act_log[vecs[i].idx].alu_op, act_log[vecs[i].idx].alu_src_a,
                  act_log[vecs[i].idx].alu_src_b}),
             32'({vecs[i].alu_op, vecs[i].src_a, vecs[i].src_b}));
      end

      // sw with two stalled cycles in MEM_WRITE
      run_instr(6'h2B, 6'h00, 2, 0, -1, n);
      cnt_w = 0;
      cnt_r = 0;
      for (int i = 0; i < n; i++) begin
         cnt_w += int'(act_log[i].mem_write);
         cnt_r += int'(act_log[i].retire);
      end
      chk("sw_stall cycles", 32'(n), 32'd6);
      chk("sw_stall mem_write cycles", 32'(cnt_w), 32'd3);
      chk("sw_stall retires", 32'(cnt_r), 32'd1);
      chk("sw_stall retire last", 32'(act_log[5].retire), 32'd1);

      // beq with zero forced high then low: controls must not change
      run_instr(6'h04, 6'h00, 0, 1, -1, n);
      run_instr(6'h04, 6'h00, 0, 0, -1, n);

      // lw with reset asserted during MEM_WB
      run_instr(6'h23, 6'h00, 0, 0, 4, n);
      @(negedge clk);
      chk("reset_hold2 ctl", 32'(sample()), 32'(at(ST_INIT)));
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);
      chk("reset_release2 ctl", 32'(sample()), 32'(at(ST_INIT)));

      // Randomized instruction stream with random memory stalls
      for (int k = 0; k < 80; k++) begin
         if ($urandom_range(0, 1) == 0) begin
            int s = $urandom_range(0, 12);
            rop = legal_ops[s];
            rfn = (legal_ops[s] == 6'h00) ? legal_fns[s] : 6'($urandom);
         end else begin
            rop = 6'($urandom);
            rfn = 6'($urandom);
         end
         run_instr(rop, rfn, 1, 2, -1, n);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
